window_5x5_scan_sequencer: RTL and testbench
============================================

Name: window_5x5_scan_sequencer

Overview:
- Frame-level sequencer for the 5x5 window buffer and its four line buffers in the filter pipeline.
- Accepts raster-order pixels and issues a shift enable to the line buffers and window registers.
- Tracks the input row and column and reports when the 5x5 window is fully valid ("valid" convolution, no padding).
- Presents each window to the downstream filter core through a registered valid/ready stage, and signals end-of-frame.

Parameters:
- IMG_W, 640, pixels per row; must be >= 5.
- IMG_H, 480, rows per frame; must be >= 5.
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin a frame; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE from any state.
- pix_valid_i  in  1  upstream pixel valid.
- pix_ready_o  out  1  upstream ready; a pixel is accepted when pix_valid_i && pix_ready_o.
- shift_en_o  out  1  combinational, equal to accept; shifts the line buffers and window registers.
- win_valid_o  out  1  window available to the downstream core.
- out_ready_i  in  1  downstream ready.
- out_col_o  out  CW  column of the window centre.
- out_row_o  out  RW  row of the window centre.
- busy_o  out  1  high in every state except IDLE.
- frame_done_o  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: state IDLE, counters 0, win_valid_o 0, out_col_o 0, out_row_o 0, frame_done_o 0. pix_ready_o, shift_en_o and busy_o are therefore 0.
- States: IDLE, PRIME, STREAM, DRAIN, DONE.
  - IDLE: start_i -> PRIME; clear the in_col and in_row counters.
  - PRIME: rows 0..3 fill the line buffers; no windows are produced. On accepting the pixel at col IMG_W-1 of row 3 -> STREAM.
  - STREAM: on accepting the pixel at (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: wait until win_valid_o && out_ready_i -> DONE.
  - DONE: assert frame_done_o for exactly 1 cycle -> IDLE.
- pix_ready_o = (state is PRIME or STREAM) && (!win_valid_o || out_ready_i). There is no skid buffer, so a downstream stall back-pressures upstream in the same cycle.
- Counters on accept:
  - in_col increments; at IMG_W-1 it wraps to 0 and in_row increments.
  - in_row never wraps inside a frame.
- Window generation:
  - gen = accept && in_row >= 4 && in_col >= 4, evaluated on the pre-increment counter values.
  - Next cycle: win_valid_o = 1, out_col_o = in_col-2, out_row_o = in_row-2.
  - Latency: 1 cycle from the accepting edge to win_valid_o.
- win_valid_o update:
  - Set by gen.
  - Cleared when out_ready_i && !gen.
  - Held, with coordinates stable, while out_ready_i is 0.
  - Simultaneous handshake and gen: stays 1 and loads the new coordinates.
- Window count: (IMG_W-4)*(IMG_H-4) per frame. Columns 0..3 of each row, and all of rows 0..3, produce none.
- abort_i has priority over every transition: go to IDLE, clear win_valid_o, clear the counters, no frame_done_o. The line-buffer contents are don't-care.
- Async reset mid-frame behaves like abort, immediately.
- start_i outside IDLE is ignored.
- pix_valid_i in IDLE or DRAIN is not accepted.

Decomposition:
- Shared package filter_pkg:
  - state encoding localparams (3 bits);
  - KERNEL = 5 and HALF = 2;
  - WIN_ROW_TH = KERNEL-1 and WIN_COL_TH = KERNEL-1.
- One natural sub-module, raster_counter: col/row counter with enable, wrap, and the flags col_eq_max, row_eq_max, col_ge_th and row_ge_th. It is reused by other kernel sizes.
- The FSM and the output stage stay in the top module.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6.
- Reset mid-frame: drop rst_n in STREAM -> all outputs 0 asynchronously; after release, state IDLE and pix_ready_o 0.
- Full frame, pix_valid_i and out_ready_i constantly 1:
  - exactly 8 windows;
  - first window is (row 2, col 2), one cycle after accepting pixel 36 (row 4, col 4);
  - last window is (3,5);
  - frame_done_o pulses 2 cycles after the last accept;
  - 48 accepts total.
- Downstream stall: hold out_ready_i 0 for 3 cycles while window (2,3) is valid -> coordinates stable, pix_ready_o 0, shift_en_o 0, no pixel lost; the remaining windows are in order.
- Upstream bubbles: random pix_valid_i at 50% -> same 8 windows and coordinates as the full-frame run; shift_en_o count is 48.
- Abort in DRAIN with win_valid_o held -> next cycle IDLE, win_valid_o 0, no frame_done_o; a new start_i produces a clean 8-window frame.
- start_i asserted during STREAM -> ignored; frame_done_o pulses exactly once.

Source files
------------

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared constants and state encoding for the filter pipeline sequencers
package filter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRIME  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int KERNEL     = 5;
    localparam int HALF       = 2;
    localparam int WIN_ROW_TH = KERNEL - 1;
    localparam int WIN_COL_TH = KERNEL - 1;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_PRIME  = ST_PRIME,
        S_STREAM = ST_STREAM,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/window_5x5_scan_sequencer_if.sv
// rtl/window_5x5_scan_sequencer_if.sv - pixel intake and window output handshake bundle
interface window_5x5_scan_sequencer_if #(
    parameter int CW = 10,
    parameter int RW = 9
);
    logic          pix_valid_i;
    logic          pix_ready_o;
    logic          shift_en_o;
    logic          win_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] out_col_o;
    logic [RW-1:0] out_row_o;

    modport master (
        input  pix_valid_i, out_ready_i,
        output pix_ready_o, shift_en_o, win_valid_o, out_col_o, out_row_o
    );

    modport slave (
        output pix_valid_i, out_ready_i,
        input  pix_ready_o, shift_en_o, win_valid_o, out_col_o, out_row_o
    );
endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster col/row position counter with kernel threshold flags
module raster_counter
    import filter_pkg::*;
#(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int CW     = $clog2(COLS),
    parameter int RW     = $clog2(ROWS),
    parameter int COL_TH = WIN_COL_TH,
    parameter int ROW_TH = WIN_ROW_TH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_eq_max,
    output logic          row_eq_max,
    output logic          col_ge_th,
    output logic          row_ge_th
);

    assign col_eq_max = (col == CW'(COLS - 1));
    assign row_eq_max = (row == RW'(ROWS - 1));
    assign col_ge_th  = (col >= CW'(COL_TH));
    assign row_ge_th  = (row >= RW'(ROW_TH));

    // Row only wraps after the very last pixel, so it never wraps inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_eq_max) begin
                col <= '0;
                row <= row_eq_max ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_5x5_scan_sequencer.sv
// rtl/window_5x5_scan_sequencer.sv - frame sequencer for the 5x5 window buffer and line buffers
module window_5x5_scan_sequencer
    import filter_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic abort_i,
    window_5x5_scan_sequencer_if.master bus,
    output logic busy_o,
    output logic frame_done_o
);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic          col_eq_max, row_eq_max, col_ge_th, row_ge_th;
    logic          feeding, accept, gen, cnt_clr;
    logic          win_valid_q;
    logic [CW-1:0] out_col_q;
    logic [RW-1:0] out_row_q;

    raster_counter #(
        .COLS   (IMG_W),
        .ROWS   (IMG_H),
        .CW     (CW),
        .RW     (RW),
        .COL_TH (WIN_COL_TH),
        .ROW_TH (WIN_ROW_TH)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .en         (accept),
        .col        (in_col),
        .row        (in_row),
        .col_eq_max (col_eq_max),
        .row_eq_max (row_eq_max),
        .col_ge_th  (col_ge_th),
        .row_ge_th  (row_ge_th)
    );

    // No skid buffer: a stalled window blocks intake in the same cycle.
    assign feeding         = (state == S_PRIME) || (state == S_STREAM);
    assign bus.pix_ready_o = feeding && (!win_valid_q || bus.out_ready_i);
    assign accept          = bus.pix_valid_i && bus.pix_ready_o;
    assign gen             = accept && row_ge_th && col_ge_th;
    assign cnt_clr         = abort_i || ((state == S_IDLE) && start_i);

    assign bus.shift_en_o  = accept;
    assign bus.win_valid_o = win_valid_q;
    assign bus.out_col_o   = out_col_q;
    assign bus.out_row_o   = out_row_q;
    assign busy_o          = (state != S_IDLE);
    assign frame_done_o    = (state == S_DONE) && !abort_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_PRIME;
            S_PRIME:  if (accept && col_eq_max && (in_row == RW'(WIN_ROW_TH - 1))) state_nxt = S_STREAM;
            S_STREAM: if (accept && col_eq_max && row_eq_max) state_nxt = S_DRAIN;
            S_DRAIN:  if (win_valid_q && bus.out_ready_i) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_i) state_nxt = S_IDLE;
    end

    // Window centre lags the newest pixel by HALF in both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else if (abort_i) begin
            win_valid_q <= 1'b0;
        end else if (gen) begin
            win_valid_q <= 1'b1;
            out_col_q   <= in_col - CW'(HALF);
            out_row_q   <= in_row - RW'(HALF);
        end else if (bus.out_ready_i) begin
            win_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_5x5_scan_sequencer.sv
// tb/tb_window_5x5_scan_sequencer.sv - self-checking bench for window_5x5_scan_sequencer
`timescale 1ns/1ps
module tb_window_5x5_scan_sequencer;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int CWT   = 3;
    localparam int RWT   = 3;
    localparam int TOTAL = W * H;
    localparam int NWIN  = (W - 4) * (H - 4);

    typedef struct {
        int vpct;
        int rpct;
        bit stall23;
        bit start_mid;
        bit timing;
        int exp_win;
        int exp_acc;
        int exp_done;
    } scen_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic busy_o, frame_done_o;

    int checks = 0;
    int failures = 0;
    int exp_r[$];
    int exp_c[$];
    scen_t scen[4];
    int feed_acc;

    window_5x5_scan_sequencer_if #(.CW(CWT), .RW(RWT)) bus ();

    window_5x5_scan_sequencer #(.IMG_W(W), .IMG_H(H), .CW(CWT), .RW(RWT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .bus          (bus),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model();
        exp_r.delete();
        exp_c.delete();
        for (int p = 0; p < TOTAL; p++) begin
            if ((p / W) >= 4 && (p % W) >= 4) begin
                exp_r.push_back(p / W - 2);
                exp_c.push_back(p % W - 2);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pix_ready"}, bus.pix_ready_o, 0);
        chk({tag, " shift_en"}, bus.shift_en_o, 0);
        chk({tag, " win_valid"}, bus.win_valid_o, 0);
        chk({tag, " out_col"}, bus.out_col_o, 0);
        chk({tag, " out_row"}, bus.out_row_o, 0);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " frame_done"}, frame_done_o, 0);
    endtask

    task automatic feed_to(input string tag, input int n);
        int t;
        t = 0;
        while (feed_acc < n && t < 500) begin
            bus.pix_valid_i = 1'b1;
            bus.out_ready_i = 1'b1;
            #1;
            if (bus.pix_ready_o === 1'b1) feed_acc++;
            step();
            t++;
        end
        chk({tag, " feed_count"}, feed_acc, n);
    endtask

    task automatic run_frame(input string tag, input scen_t sc);
        int nacc = 0, nwin = 0, ndone = 0;
        int first_win = -1, acc36 = -1, last_acc = -1, done_cyc = -1;
        int stall_left = 0, post = -1;
        bit stalled = 0, started = 0, prev_stall = 0;
        bit pv, rdy, wv, exp_rdy;
        logic [CWT-1:0] pcol;
        logic [RWT-1:0] prow;
        pcol = '0;
        prow = '0;
        bus.pix_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            wv = bus.win_valid_o;
            if (frame_done_o === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = t;
                    post = 3;
                end
            end
            if (wv && first_win < 0) first_win = t;
            if (prev_stall) begin
                chk({tag, " hold_valid"}, wv, 1);
                chk({tag, " hold_col"}, bus.out_col_o, pcol);
                chk({tag, " hold_row"}, bus.out_row_o, prow);
            end
            if (post == 0) break;
            if (sc.stall23 && !stalled && wv && bus.out_row_o == 2 && bus.out_col_o == 3) begin
                stalled = 1;
                stall_left = 3;
            end
            pv = ($urandom_range(99) < sc.vpct);
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(99) < sc.rpct);
            end
            start_i = sc.start_mid && !started && nacc == 40;
            if (start_i) started = 1;
            bus.pix_valid_i = pv;
            bus.out_ready_i = rdy;
            #1;
            exp_rdy = (nacc < TOTAL) && (!wv || rdy);
            chk({tag, " pix_ready"}, bus.pix_ready_o, exp_rdy);
            chk({tag, " shift_en"}, bus.shift_en_o, pv && exp_rdy);
            if (pv && bus.pix_ready_o === 1'b1) begin
                if (nacc == 36) acc36 = t;
                last_acc = t;
                nacc++;
            end
            if (wv && rdy) begin
                if (nwin < exp_r.size()) begin
                    chk({tag, " win_row"}, bus.out_row_o, exp_r[nwin]);
                    chk({tag, " win_col"}, bus.out_col_o, exp_c[nwin]);
                end else begin
                    chk({tag, " win_overflow"}, nwin, NWIN - 1);
                end
                nwin++;
            end
            prev_stall = wv && !rdy;
            pcol = bus.out_col_o;
            prow = bus.out_row_o;
            step();
            if (post > 0) post--;
        end
        start_i = 1'b0;
        bus.pix_valid_i = 1'b0;
        chk({tag, " windows"}, nwin, sc.exp_win);
        chk({tag, " accepts"}, nacc, sc.exp_acc);
        chk({tag, " done_pulses"}, ndone, sc.exp_done);
        chk({tag, " idle_after"}, busy_o, 0);
        chk({tag, " first_win_latency"}, first_win, acc36 + 1);
        if (sc.timing) chk({tag, " done_latency"}, done_cyc, last_acc + 2);
        if (sc.stall23) chk({tag, " stall_seen"}, stalled, 1);
    endtask

    initial begin
        scen[0] = '{vpct: 100, rpct: 100, stall23: 0, start_mid: 0, timing: 1, exp_win: NWIN, exp_acc: TOTAL, exp_done: 1};
        scen[1] = '{vpct: 100, rpct: 100, stall23: 1, start_mid: 0, timing: 1, exp_win: NWIN, exp_acc: TOTAL, exp_done: 1};
        scen[2] = '{vpct: 50,  rpct: 70,  stall23: 0, start_mid: 0, timing: 0, exp_win: NWIN, exp_acc: TOTAL, exp_done: 1};
        scen[3] = '{vpct: 100, rpct: 100, stall23: 0, start_mid: 1, timing: 1, exp_win: NWIN, exp_acc: TOTAL, exp_done: 1};
        build_model();
        chk("model_first_row", exp_r[0], 2);
        chk("model_last_col", exp_c[NWIN - 1], 5);

        bus.pix_valid_i = 1'b1;
        bus.out_ready_i = 1'b1;
        #2;
        check_all_zero("reset");
        #5 rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("scen%0d", i), scen[i]);
        end

        feed_acc = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        feed_to("rst_mid", 40);
        chk("rst_mid in_stream", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid async");
        #3 rst_n = 1'b1;
        step();
        bus.pix_valid_i = 1'b1;
        #1;
        chk("rst_mid post busy", busy_o, 0);
        chk("rst_mid post pix_ready", bus.pix_ready_o, 0);
        chk("rst_mid post shift_en", bus.shift_en_o, 0);
        step();

        feed_acc = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        feed_to("abort", TOTAL);
        bus.out_ready_i = 1'b0;
        chk("abort drain win_valid", bus.win_valid_o, 1);
        chk("abort drain busy", busy_o, 1);
        step();
        chk("abort drain held", bus.win_valid_o, 1);
        abort_i = 1'b1;
        #1;
        chk("abort frame_done", frame_done_o, 0);
        step();
        abort_i = 1'b0;
        chk("abort idle busy", busy_o, 0);
        chk("abort win_valid", bus.win_valid_o, 0);
        chk("abort frame_done_next", frame_done_o, 0);
        step();
        chk("abort frame_done_late", frame_done_o, 0);
        run_frame("after_abort", scen[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
